// File: rtl/cpu_exec_pkg.sv
// rtl/cpu_exec_pkg.sv - shared ALU funct codes, MIPS opcode/funct fields and ExcCodes
package cpu_exec_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_ADDU = 4'b0001;
  localparam logic [3:0] FN_SUB  = 4'b0010;
  localparam logic [3:0] FN_SUBU = 4'b0011;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_XOR  = 4'b0110;
  localparam logic [3:0] FN_NOR  = 4'b0111;
  localparam logic [3:0] FN_SLT  = 4'b1010;
  localparam logic [3:0] FN_SLTU = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [4:0] EXC_OV_DEF = 5'd12;
  localparam logic [4:0] EXC_RI_DEF = 5'd10;

  typedef struct packed {
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/cpu_execution_issue_decode.sv
// rtl/cpu_execution_issue_decode.sv - combinational MIPS ALU-class decode to funct/operands
module cpu_execution_issue_decode
  import cpu_exec_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [3:0]  funct_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  dest_o,
  output logic        illegal_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = instr_i[31:26];
  assign fn       = instr_i[5:0];
  assign imm_sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext = {16'h0000, instr_i[15:0]};

  // Unknown encodings issue as a harmless addu with no destination.
  always_comb begin
    funct_o   = FN_ADDU;
    a_o       = rs_val_i;
    b_o       = rt_val_i;
    dest_o    = '0;
    illegal_o = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest_o = instr_i[15:11];
        case (fn)
          F_ADD:   funct_o = FN_ADD;
          F_ADDU:  funct_o = FN_ADDU;
          F_SUB:   funct_o = FN_SUB;
          F_SUBU:  funct_o = FN_SUBU;
          F_AND:   funct_o = FN_AND;
          F_OR:    funct_o = FN_OR;
          F_XOR:   funct_o = FN_XOR;
          F_NOR:   funct_o = FN_NOR;
          F_SLT:   funct_o = FN_SLT;
          F_SLTU:  funct_o = FN_SLTU;
          default: begin
            illegal_o = 1'b1;
            dest_o    = '0;
          end
        endcase
      end
      OP_ADDI:  begin funct_o = FN_ADD;  b_o = imm_sext; dest_o = instr_i[20:16]; end
      OP_ADDIU: begin funct_o = FN_ADDU; b_o = imm_sext; dest_o = instr_i[20:16]; end
      OP_SLTI:  begin funct_o = FN_SLT;  b_o = imm_sext; dest_o = instr_i[20:16]; end
      OP_SLTIU: begin funct_o = FN_SLTU; b_o = imm_sext; dest_o = instr_i[20:16]; end
      OP_ANDI:  begin funct_o = FN_AND;  b_o = imm_zext; dest_o = instr_i[20:16]; end
      OP_ORI:   begin funct_o = FN_OR;   b_o = imm_zext; dest_o = instr_i[20:16]; end
      OP_XORI:  begin funct_o = FN_XOR;  b_o = imm_zext; dest_o = instr_i[20:16]; end
      OP_LUI: begin
        funct_o = FN_OR;
        a_o     = '0;
        b_o     = {instr_i[15:0], 16'h0000};
        dest_o  = instr_i[20:16];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_execution_issue.sv
// rtl/cpu_execution_issue.sv - issue register, writeback register and precise exception latch
module cpu_execution_issue
  import cpu_exec_pkg::*;
#(
  parameter int         XLEN   = XLEN_DEF,
  parameter logic [4:0] EXC_OV = EXC_OV_DEF,
  parameter logic [4:0] EXC_RI = EXC_RI_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_funct,
  output logic [XLEN-1:0] out_oper_a,
  output logic [XLEN-1:0] out_oper_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_overflow,
  input  logic            alu_badfunct,
  output logic            wb_valid,
  output logic [4:0]      wb_dest,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic [4:0]      exc_code,
  output logic [XLEN-1:0] exc_pc,
  input  logic            exc_ack
);

  issue_entry_t entry_q, entry_d, dec_entry;
  logic         valid_q, valid_d;
  logic         wb_valid_q, wb_valid_d;
  logic [4:0]   wb_dest_q, wb_dest_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic         exc_valid_q, exc_valid_d;
  logic [4:0]   exc_code_q, exc_code_d;
  logic [31:0]  exc_pc_q, exc_pc_d;
  logic         in_fire, out_fire, exc_raise;

  cpu_execution_issue_decode u_decode (
    .instr_i   (in_instr),
    .rs_val_i  (in_rs_val),
    .rt_val_i  (in_rt_val),
    .funct_o   (dec_entry.funct),
    .a_o       (dec_entry.a),
    .b_o       (dec_entry.b),
    .dest_o    (dec_entry.dest),
    .illegal_o (dec_entry.illegal)
  );
  assign dec_entry.pc = in_pc;

  assign in_ready  = resetn & ~exc_valid_q & (~valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = valid_q & out_ready;
  assign exc_raise = out_fire & (entry_q.illegal | alu_badfunct | alu_overflow);

  always_comb begin
    valid_d     = valid_q;
    entry_d     = entry_q;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = exc_valid_q;
    exc_code_d  = exc_code_q;
    exc_pc_d    = exc_pc_q;
    if (in_fire) begin
      valid_d = 1'b1;
      entry_d = dec_entry;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    // A faulting entry flushes anything accepted behind it in the same cycle.
    if (exc_raise) valid_d = 1'b0;
    wb_valid_d = out_fire & ~exc_raise & (entry_q.dest != 5'd0);
    if (wb_valid_d) begin
      wb_dest_d = entry_q.dest;
      wb_data_d = alu_result;
    end
    if (exc_raise) begin
      exc_valid_d = 1'b1;
      exc_code_d  = (entry_q.illegal | alu_badfunct) ? EXC_RI : EXC_OV;
      exc_pc_d    = entry_q.pc;
    end else if (exc_ack) begin
      exc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= 1'b0;
      entry_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_pc_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      entry_q     <= entry_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_funct  = entry_q.funct;
  assign out_oper_a = entry_q.a;
  assign out_oper_b = entry_q.b;
  assign wb_valid   = wb_valid_q;
  assign wb_dest    = wb_dest_q;
  assign wb_data    = wb_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign exc_pc     = exc_pc_q;

endmodule
